multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Moore-style control FSM for the multi-cycle RV32I datapath, and the initiator of the ALU's `ALU_Operation` interface. It sequences each instruction through fetch, decode, execute, memory and writeback cycles. In each cycle it drives the ALU operation code, the datapath mux selects and the write enables, and it reads back the ALU `Zero` flag for branches. It replaces the single-cycle combinational control and sits between the instruction register and the shared datapath/memory.

## Interface
No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state IDLE
- Opcode_i  in  7  IR[6:0]
- Funct3_i  in  3  IR[14:12]
- Funct7_i  in  7  IR[31:25]
- Zero_i  in  1  ALU zero flag
- ALU_Operation_o  out  4  ADD=0000, SUB=0001, LUI=0010, ORI=0011, SLLI=0100
- ALU_Src_A_o  out  2  00=PC, 01=Old_PC, 10=rs1 register
- ALU_Src_B_o  out  2  00=rs2 register, 01=immediate, 10=constant 4
- Result_Src_o  out  2  00=ALUOut register, 01=MDR, 10=ALU result direct
- IorD_o  out  1  memory address source: 0=PC, 1=ALUOut
- Mem_Read_o / Mem_Write_o  out  1 each  memory strobes
- IR_Write_o  out  1  load IR and Old_PC
- Reg_Write_o  out  1  register file write enable
- PC_Src_o  out  1  0=ALU result, 1=ALUOut
- PC_En_o  out  1  PC load enable
- Illegal_o  out  1  sticky unsupported-instruction flag
- State_o  out  4  current state, for debug

## Operation
- All outputs are a pure function of the state register (Moore).
- Exception: `PC_En_o = PC_Write | (Branch & Zero_i)`, where PC_Write and Branch are internal state decodes.
- Unlisted outputs are 0 in every state; an unlisted ALU_Operation is ADD.

States and their asserted outputs:
- IDLE (reset state): all outputs 0. Next state is FETCH.
- FETCH
  - Outputs: IorD=0, Mem_Read, IR_Write, Src_A=00, Src_B=10, ADD, PC_Src=0, PC_Write.
  - Next state: DECODE.
- DECODE
  - Outputs: Src_A=01, Src_B=01, ADD. The branch/jump target is latched in ALUOut.
  - Next state is taken from the decode rules below.
- EXEC_R: Src_A=10, Src_B=00; op is ADD for funct7=0000000, SUB for 0100000. Next: ALU_WB.
- EXEC_I: Src_A=10, Src_B=01; op is ADD (funct3 000), ORI (110) or SLLI (001). Next: ALU_WB.
- EXEC_U: Src_B=01, op LUI. Next: ALU_WB.
- ALU_WB: Reg_Write, Result_Src=00. Next: FETCH.
- MEM_ADDR: Src_A=10, Src_B=01, ADD. Next: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: IorD=1, Mem_Read. Next: MEM_WB.
- MEM_WB: Reg_Write, Result_Src=01. Next: FETCH.
- MEM_WRITE: IorD=1, Mem_Write. Next: FETCH.
- BRANCH: Src_A=10, Src_B=00, SUB, Branch, PC_Src=1. Next: FETCH.
- JAL
  - Outputs: Src_A=01, Src_B=10, ADD, Reg_Write, Result_Src=10, PC_Src=1, PC_Write.
  - The link value Old_PC+4 is written to rd, and the target is taken from ALUOut.
  - Next: FETCH.
- ILLEGAL: Illegal_o=1, all other outputs 0. Stays in ILLEGAL until reset.

Decode rules in DECODE (any other combination goes to ILLEGAL):
- 0110011 (R-type): funct3=000 and funct7 is 0000000 or 0100000 -> EXEC_R
- 0010011 (I-type ALU): funct3 000 or 110 -> EXEC_I; funct3 001 with funct7=0000000 -> EXEC_I
- 0110111 (lui) -> EXEC_U
- 0000011 (load) with funct3=010 -> MEM_ADDR
- 0100011 (store) with funct3=010 -> MEM_ADDR
- 1100011 (branch) with funct3=000 -> BRANCH
- 1101111 (jal) -> JAL

## Timing
- Cycles per instruction, counting FETCH: beq 3, jal 3, R/I/U-type 4, sw 4, lw 5.
- Opcode/Funct inputs are valid from DECODE onward. The IR loads on the FETCH→DECODE edge.
- Zero_i is sampled combinationally in BRANCH only. When the branch is not taken, PC_En_o stays 0 and the PC holds PC+4 from fetch.
- Reset: asynchronous assertion → state IDLE; every output is 0 within the same cycle, including mid-instruction.
  - Deassertion: the first edge goes to FETCH.
  - A store interrupted by reset must not issue Mem_Write afterward.
- Exactly one of Mem_Read/Mem_Write/Reg_Write-with-MDR is active per memory phase. Mem_Read and Mem_Write are never both asserted.
- State_o encoding: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, EXEC_U=5, ALU_WB=6, MEM_ADDR=7, MEM_READ=8, MEM_WB=9, MEM_WRITE=10, BRANCH=11, JAL=12, ILLEGAL=15.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - the opcode constants, the ALU operation codes (shared with the ALU), the state enum, and the mux-select encodings above;
  - the state encoding is shared so that the bench can decode State_o.
- One natural sub-module, `alu_op_decoder`: combinational (state, funct3, funct7) → ALU_Operation_o. The FSM itself holds only the state register, next-state logic and the output decode.

## Test plan
- Reset asserted mid-MEM_ADDR of sw → same-cycle outputs all 0, State_o=0. After release: FETCH, DECODE, then MEM_ADDR again; Mem_Write only in the MEM_WRITE cycle.
- add (0110011/000/0000000) then sub (funct7 0100000) → states 1,2,3,6; ALU_Operation 0000 then 0001 in EXEC_R; Reg_Write only in ALU_WB.
- ori, slli, lui → EXEC ops 0011, 0100, 0010 respectively. slli with funct7=0100000 → ILLEGAL, Illegal_o=1 held for 10 cycles until reset.
- lw (0000011/010) → 5 cycles: IorD=1 with Mem_Read in MEM_READ; Result_Src=01 with Reg_Write in MEM_WB.
- beq with Zero_i=1 → PC_En_o=1 in BRANCH with PC_Src=1. With Zero_i=0 → PC_En_o=0; next state FETCH in both cases.
- jal → DECODE then JAL: Reg_Write=1, Result_Src=10, PC_En_o=1, PC_Src=1, Src_A=01, Src_B=10; then FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit.
//   - opcode / funct constants used by the instruction decoder
//   - ALU operation codes, shared with the ALU
//   - control FSM state encoding, visible on State_o for debug
//   - datapath mux-select encodings
//   - decode_next(): DECODE-state dispatch on the instruction fields
package riscv_ctrl_pkg;

  // Opcodes (IR[6:0])
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // funct3 (IR[14:12]) / funct7 (IR[31:25]) values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation codes
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_LUI  = 4'b0010,
    ALU_ORI  = 4'b0011,
    ALU_SLLI = 4'b0100
  } alu_op_e;

  // Control FSM states
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EXEC_R    = 4'd3,
    ST_EXEC_I    = 4'd4,
    ST_EXEC_U    = 4'd5,
    ST_ALU_WB    = 4'd6,
    ST_MEM_ADDR  = 4'd7,
    ST_MEM_READ  = 4'd8,
    ST_MEM_WB    = 4'd9,
    ST_MEM_WRITE = 4'd10,
    ST_BRANCH    = 4'd11,
    ST_JAL       = 4'd12,
    ST_ILLEGAL   = 4'd15
  } state_e;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_MDR     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // Next state out of DECODE; anything unsupported lands in ST_ILLEGAL.
  function automatic state_e decode_next(input logic [6:0] opcode,
                                         input logic [2:0] funct3,
                                         input logic [6:0] funct7);
    state_e nxt;
    nxt = ST_ILLEGAL;
    case (opcode)
      OPC_R:
        if (funct3 == F3_ADD && (funct7 == F7_BASE || funct7 == F7_ALT))
          nxt = ST_EXEC_R;
      OPC_I:
        if (funct3 == F3_ADD || funct3 == F3_OR)
          nxt = ST_EXEC_I;
        else if (funct3 == F3_SLL && funct7 == F7_BASE)
          nxt = ST_EXEC_I;
      OPC_LUI:
        nxt = ST_EXEC_U;
      OPC_LOAD, OPC_STORE:
        if (funct3 == F3_WORD)
          nxt = ST_MEM_ADDR;
      OPC_BRANCH:
        if (funct3 == F3_BEQ)
          nxt = ST_BRANCH;
      OPC_JAL:
        nxt = ST_JAL;
      default:
        nxt = ST_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_op_decoder.sv
// alu_op_decoder: combinational ALU operation select for the control FSM.
//   state_i   current FSM state
//   funct3_i  IR[14:12]
//   funct7_i  IR[31:25]
//   alu_op_o  operation code driven to the ALU (ADD in every state
//             that does not need something else)
module alu_op_decoder
  import riscv_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  output alu_op_e     alu_op_o
);

  always_comb begin
    // NOTE: default first so every path assigns alu_op_o and no latch is inferred.
    alu_op_o = ALU_ADD;
    case (state_i)
      // Decode already restricted funct7 to BASE/ALT, so ALT means sub.
      ST_EXEC_R: alu_op_o = (funct7_i == F7_ALT) ? ALU_SUB : ALU_ADD;
      ST_EXEC_I: begin
        if (funct3_i == F3_OR)       alu_op_o = ALU_ORI;
        else if (funct3_i == F3_SLL) alu_op_o = ALU_SLLI;
        else                         alu_op_o = ALU_ADD;
      end
      ST_EXEC_U: alu_op_o = ALU_LUI;
      // beq compares rs1 - rs2 against zero.
      ST_BRANCH: alu_op_o = ALU_SUB;
      default:   alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore control FSM for the multi-cycle RV32I
// datapath. Sequences fetch / decode / execute / memory / writeback.
//   clk, reset          rising-edge clock, async active-high reset (-> IDLE)
//   Opcode_i/Funct3_i/Funct7_i  instruction fields from IR, valid from DECODE
//   Zero_i              ALU zero flag, used only in BRANCH
//   ALU_Operation_o     ALU operation code
//   ALU_Src_A_o/B_o     ALU operand selects
//   Result_Src_o        register write-data select
//   IorD_o              memory address select (0=PC, 1=ALUOut)
//   Mem_Read_o/Mem_Write_o  memory strobes
//   IR_Write_o          load IR and Old_PC
//   Reg_Write_o         register file write enable
//   PC_Src_o, PC_En_o   PC next-value select and load enable
//   Illegal_o           sticky unsupported-instruction flag (until reset)
//   State_o             current state, for debug
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode_i,
  input  logic [2:0] Funct3_i,
  input  logic [6:0] Funct7_i,
  input  logic       Zero_i,
  output logic [3:0] ALU_Operation_o,
  output logic [1:0] ALU_Src_A_o,
  output logic [1:0] ALU_Src_B_o,
  output logic [1:0] Result_Src_o,
  output logic       IorD_o,
  output logic       Mem_Read_o,
  output logic       Mem_Write_o,
  output logic       IR_Write_o,
  output logic       Reg_Write_o,
  output logic       PC_Src_o,
  output logic       PC_En_o,
  output logic       Illegal_o,
  output logic [3:0] State_o
);

  state_e  state_q, state_d;
  alu_op_e alu_op;
  logic    pc_write;
  logic    branch;

  // NOTE: state flops use non-blocking assignments; reset is asynchronous so
  // every Moore output drops to its IDLE value without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_DECODE;
      ST_DECODE:    state_d = decode_next(Opcode_i, Funct3_i, Funct7_i);
      ST_EXEC_R,
      ST_EXEC_I,
      ST_EXEC_U:    state_d = ST_ALU_WB;
      ST_ALU_WB:    state_d = ST_FETCH;
      // Only lw and sw reach MEM_ADDR, so the store opcode alone splits them.
      ST_MEM_ADDR:  state_d = (Opcode_i == OPC_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  state_d = ST_MEM_WB;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JAL:       state_d = ST_FETCH;
      ST_ILLEGAL:   state_d = ST_ILLEGAL;
      default:      state_d = ST_ILLEGAL;
    endcase
  end

  // Moore output decode
  always_comb begin
    ALU_Src_A_o  = SRC_A_PC;
    ALU_Src_B_o  = SRC_B_RS2;
    Result_Src_o = RES_ALU_OUT;
    IorD_o       = 1'b0;
    Mem_Read_o   = 1'b0;
    Mem_Write_o  = 1'b0;
    IR_Write_o   = 1'b0;
    Reg_Write_o  = 1'b0;
    PC_Src_o     = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    Illegal_o    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        Mem_Read_o  = 1'b1;
        IR_Write_o  = 1'b1;
        ALU_Src_A_o = SRC_A_PC;
        ALU_Src_B_o = SRC_B_FOUR;
        pc_write    = 1'b1;
      end
      // Old_PC + imm is computed here and held in ALUOut as branch/jump target.
      ST_DECODE: begin
        ALU_Src_A_o = SRC_A_OLD_PC;
        ALU_Src_B_o = SRC_B_IMM;
      end
      ST_EXEC_R: begin
        ALU_Src_A_o = SRC_A_RS1;
        ALU_Src_B_o = SRC_B_RS2;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        ALU_Src_A_o = SRC_A_RS1;
        ALU_Src_B_o = SRC_B_IMM;
      end
      ST_EXEC_U: ALU_Src_B_o = SRC_B_IMM;
      ST_ALU_WB: begin
        Reg_Write_o  = 1'b1;
        Result_Src_o = RES_ALU_OUT;
      end
      ST_MEM_READ: begin
        IorD_o     = 1'b1;
        Mem_Read_o = 1'b1;
      end
      ST_MEM_WB: begin
        Reg_Write_o  = 1'b1;
        Result_Src_o = RES_MDR;
      end
      ST_MEM_WRITE: begin
        IorD_o      = 1'b1;
        Mem_Write_o = 1'b1;
      end
      ST_BRANCH: begin
        ALU_Src_A_o = SRC_A_RS1;
        ALU_Src_B_o = SRC_B_RS2;
        branch      = 1'b1;
        PC_Src_o    = 1'b1;
      end
      // Link = Old_PC + 4 goes straight from the ALU to rd; target from ALUOut.
      ST_JAL: begin
        ALU_Src_A_o  = SRC_A_OLD_PC;
        ALU_Src_B_o  = SRC_B_FOUR;
        Reg_Write_o  = 1'b1;
        Result_Src_o = RES_ALU;
        PC_Src_o     = 1'b1;
        pc_write     = 1'b1;
      end
      ST_ILLEGAL: Illegal_o = 1'b1;
      default: ;
    endcase
  end

  // The only non-Moore output: a taken branch needs the live Zero flag.
  assign PC_En_o         = pc_write | (branch & Zero_i);
  assign ALU_Operation_o = alu_op;
  assign State_o         = state_q;

  alu_op_decoder u_alu_op_decoder (
    .state_i  (state_q),
    .funct3_i (Funct3_i),
    .funct7_i (Funct7_i),
    .alu_op_o (alu_op)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit.
module tb_multicycle_control_unit;
  import riscv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode_i;
  logic [2:0] Funct3_i;
  logic [6:0] Funct7_i;
  logic       Zero_i;
  logic [3:0] ALU_Operation_o;
  logic [1:0] ALU_Src_A_o, ALU_Src_B_o, Result_Src_o;
  logic       IorD_o, Mem_Read_o, Mem_Write_o, IR_Write_o, Reg_Write_o;
  logic       PC_Src_o, PC_En_o, Illegal_o;
  logic [3:0] State_o;

  int checks = 0;
  int errors = 0;

  multicycle_control_unit dut (
    .clk             (clk),
    .reset           (reset),
    .Opcode_i        (Opcode_i),
    .Funct3_i        (Funct3_i),
    .Funct7_i        (Funct7_i),
    .Zero_i          (Zero_i),
    .ALU_Operation_o (ALU_Operation_o),
    .ALU_Src_A_o     (ALU_Src_A_o),
    .ALU_Src_B_o     (ALU_Src_B_o),
    .Result_Src_o    (Result_Src_o),
    .IorD_o          (IorD_o),
    .Mem_Read_o      (Mem_Read_o),
    .Mem_Write_o     (Mem_Write_o),
    .IR_Write_o      (IR_Write_o),
    .Reg_Write_o     (Reg_Write_o),
    .PC_Src_o        (PC_Src_o),
    .PC_En_o         (PC_En_o),
    .Illegal_o       (Illegal_o),
    .State_o         (State_o)
  );

  always #5 clk = ~clk;

  // Observed output bundle:
  // {state, alu_op, src_a, src_b, result_src, iord, mem_rd, mem_wr, ir_wr,
  //  reg_wr, pc_src, pc_en, illegal}
  function automatic logic [21:0] observed();
    return {State_o, ALU_Operation_o, ALU_Src_A_o, ALU_Src_B_o, Result_Src_o,
            IorD_o, Mem_Read_o, Mem_Write_o, IR_Write_o, Reg_Write_o,
            PC_Src_o, PC_En_o, Illegal_o};
  endfunction

  // Expected bundle per state, hand-written from the state table.
  // alu and pc_en are passed in because they depend on the instruction / Zero.
  function automatic logic [21:0] expected(input logic [3:0] st,
                                           input logic [3:0] alu,
                                           input logic       pc_en);
    logic [21:0] e;
    case (st)
      4'd0:  e = {4'd0,  4'd0, 2'b00, 2'b00, 2'b00, 8'b0000_0000};
      4'd1:  e = {4'd1,  4'd0, 2'b00, 2'b10, 2'b00, 8'b0101_0010};
      4'd2:  e = {4'd2,  4'd0, 2'b01, 2'b01, 2'b00, 8'b0000_0000};
      4'd3:  e = {4'd3,  alu,  2'b10, 2'b00, 2'b00, 8'b0000_0000};
      4'd4:  e = {4'd4,  alu,  2'b10, 2'b01, 2'b00, 8'b0000_0000};
      4'd5:  e = {4'd5,  4'd2, 2'b00, 2'b01, 2'b00, 8'b0000_0000};
      4'd6:  e = {4'd6,  4'd0, 2'b00, 2'b00, 2'b00, 8'b0000_1000};
      4'd7:  e = {4'd7,  4'd0, 2'b10, 2'b01, 2'b00, 8'b0000_0000};
      4'd8:  e = {4'd8,  4'd0, 2'b00, 2'b00, 2'b00, 8'b1100_0000};
      4'd9:  e = {4'd9,  4'd0, 2'b00, 2'b00, 2'b01, 8'b0000_1000};
      4'd10: e = {4'd10, 4'd0, 2'b00, 2'b00, 2'b00, 8'b1010_0000};
      4'd11: e = {4'd11, 4'd1, 2'b10, 2'b00, 2'b00, 6'b0000_01, pc_en, 1'b0};
      4'd12: e = {4'd12, 4'd0, 2'b01, 2'b10, 2'b10, 8'b0000_1110};
      default: e = {4'd15, 4'd0, 2'b00, 2'b00, 2'b00, 8'b0000_0001};
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] st,
                             input logic [3:0] alu = 4'd0, input logic pc_en = 1'b0);
    check(tag, {10'd0, observed()}, {10'd0, expected(st, alu, pc_en)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    Opcode_i = op;
    Funct3_i = f3;
    Funct7_i = f7;
  endtask

  initial begin
    reset = 1'b1;
    Zero_i = 1'b1;   // held high so a stray Branch decode would show on PC_En
    set_instr(7'b0100011, 3'b010, 7'b0000000);  // sw

    // Reset state
    tick();
    check_state("reset_idle", 4'd0);
    tick();
    check_state("reset_idle_hold", 4'd0);

    // sw interrupted by reset in MEM_ADDR
    reset = 1'b0;
    tick(); check_state("sw_fetch", 4'd1);
    tick(); check_state("sw_decode", 4'd2);
    tick(); check_state("sw_mem_addr", 4'd7);
    #2 reset = 1'b1;
    #1 check_state("sw_async_reset", 4'd0);
    tick(); check_state("sw_reset_held", 4'd0);
    reset = 1'b0;
    tick(); check_state("sw_re_fetch", 4'd1);
    tick(); check_state("sw_re_decode", 4'd2);
    tick(); check_state("sw_re_mem_addr", 4'd7);
    tick(); check_state("sw_mem_write", 4'd10);
    check("sw_mem_write_strobe", {31'd0, Mem_Write_o}, 32'd1);
    tick(); check_state("sw_back_fetch", 4'd1);

    // add
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    tick(); check_state("add_decode", 4'd2);
    tick(); check_state("add_exec", 4'd3, 4'b0000);
    tick(); check_state("add_wb", 4'd6);
    tick(); check_state("add_fetch", 4'd1);

    // sub
    set_instr(7'b0110011, 3'b000, 7'b0100000);
    tick(); check_state("sub_decode", 4'd2);
    tick(); check_state("sub_exec", 4'd3, 4'b0001);
    tick(); check_state("sub_wb", 4'd6);
    tick(); check_state("sub_fetch", 4'd1);

    // ori
    set_instr(7'b0010011, 3'b110, 7'b0000000);
    tick(); tick(); check_state("ori_exec", 4'd4, 4'b0011);
    tick(); check_state("ori_wb", 4'd6);
    tick(); check_state("ori_fetch", 4'd1);

    // slli
    set_instr(7'b0010011, 3'b001, 7'b0000000);
    tick(); tick(); check_state("slli_exec", 4'd4, 4'b0100);
    tick(); tick(); check_state("slli_fetch", 4'd1);

    // lui
    set_instr(7'b0110111, 3'b101, 7'b1010101);
    tick(); tick(); check_state("lui_exec", 4'd5, 4'b0010);
    tick(); check_state("lui_wb", 4'd6);
    tick(); check_state("lui_fetch", 4'd1);

    // lw: 5 cycles
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    tick(); check_state("lw_decode", 4'd2);
    tick(); check_state("lw_mem_addr", 4'd7);
    tick(); check_state("lw_mem_read", 4'd8);
    tick(); check_state("lw_mem_wb", 4'd9);
    tick(); check_state("lw_fetch", 4'd1);

    // beq taken
    set_instr(7'b1100011, 3'b000, 7'b0000000);
    tick(); check_state("beq_t_decode", 4'd2);
    tick(); check_state("beq_t_branch", 4'd11, 4'd1, 1'b1);
    tick(); check_state("beq_t_fetch", 4'd1);

    // beq not taken
    tick(); check_state("beq_n_decode", 4'd2);
    Zero_i = 1'b0;
    tick(); check_state("beq_n_branch", 4'd11, 4'd1, 1'b0);
    Zero_i = 1'b1;
    #1 check("beq_n_zero_live", {31'd0, PC_En_o}, 32'd1);
    tick(); check_state("beq_n_fetch", 4'd1);

    // jal
    set_instr(7'b1101111, 3'b011, 7'b1111111);
    tick(); check_state("jal_decode", 4'd2);
    tick(); check_state("jal_exec", 4'd12);
    tick(); check_state("jal_fetch", 4'd1);

    // illegal R-type funct3
    set_instr(7'b0110011, 3'b111, 7'b0000000);
    tick(); tick(); check_state("r_f3_illegal", 4'd15);
    reset = 1'b1;
    #1 check_state("ill_reset_a", 4'd0);
    tick(); reset = 1'b0;
    tick(); check_state("ill_reset_fetch", 4'd1);

    // slli with funct7=0100000 -> ILLEGAL, sticky for 10 cycles
    set_instr(7'b0010011, 3'b001, 7'b0100000);
    tick(); check_state("slli_bad_decode", 4'd2);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_state($sformatf("illegal_hold_%0d", i), 4'd15);
    end
    reset = 1'b1;
    #1 check_state("illegal_cleared", 4'd0);
    tick(); reset = 1'b0;
    tick(); check_state("final_fetch", 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
